// File: rtl/ksa2_result_checker.sv
// Capture/compare stage for the 2-bit KSA adder.
// Each operand vector launched into the adder is shadowed through a LATENCY-deep
// delay line carrying its index and expected {cout,sum1,sum0}. The tail of the
// line is compared with the adder outputs. Mismatches and unexpected pulses are
// counted, and the first failure is kept.
module ksa2_result_checker #(
  parameter int LATENCY    = 3,
  parameter int WARMUP_CYC = 20,
  parameter int CNT_W      = 8
) (
  input  logic             GCLK_Pad,
  input  logic             RST_Pad,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic             a0_Pad,
  input  logic             a1_Pad,
  input  logic             b0_Pad,
  input  logic             b1_Pad,
  input  logic             cin_Pad,
  input  logic             sum0_Pad,
  input  logic             sum1_Pad,
  input  logic             cout_Pad,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_exp,
  output logic [2:0]       first_err_got
);

  localparam int TMAX = (WARMUP_CYC > LATENCY) ? WARMUP_CYC : LATENCY;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [TW-1:0]                     tmr_q, tmr_d;
  logic [LATENCY-1:0]                vld_pipe_q;
  logic [LATENCY-1:0][CNT_W-1:0]     idx_pipe_q;
  logic [LATENCY-1:0][2:0]           exp_pipe_q;
  logic [CNT_W-1:0]                  vec_q, vec_d, err_q, err_d, fidx_q;
  logic [2:0]                        fexp_q, fgot_q;
  logic                              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                              start_acc, accept, err_hit;
  logic [2:0]                        got, exp_new;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = vec_valid && (state_q == S_RUN);
  assign got       = {cout_Pad, sum1_Pad, sum0_Pad};
  assign exp_new   = {1'b0, a1_Pad, a0_Pad} + {1'b0, b1_Pad, b0_Pad} + {2'b00, cin_Pad};

  // Tail entry was pushed LATENCY cycles ago; an empty tail expects silence.
  assign err_hit = (state_q == S_RUN || state_q == S_DRAIN) &&
                   (vld_pipe_q[LATENCY-1] ? (got != exp_pipe_q[LATENCY-1]) : (got != 3'b000));

  // Session state register and phase timer
  always_ff @(posedge GCLK_Pad) begin
    if (RST_Pad) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state: warm-up and drain both run off the same timer, cleared on every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_WARMUP;
      S_WARMUP: if (tmr_q == TW'(WARMUP_CYC - 1)) state_d = S_RUN;
      S_RUN:    if (vec_valid && vec_last) state_d = S_DRAIN;
      S_DRAIN:  if (tmr_q == TW'(LATENCY - 1)) state_d = S_DONE;
      S_DONE:   if (start) state_d = S_WARMUP;
      default:  state_d = S_IDLE;
    endcase
    tmr_d = (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) ? '0 : tmr_q + 1'b1;
  end

  // Next values of the registered outputs; counters saturate at all-ones
  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    if (start_acc) begin
      vec_d = '0;
      err_d = '0;
    end else begin
      if (accept && !(&vec_q)) vec_d = vec_q + 1'b1;
      if (err_hit && !(&err_q)) err_d = err_q + 1'b1;
    end
    busy_d = (state_d == S_WARMUP || state_d == S_RUN || state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0) && (vec_d != '0);
  end

  // Delay line, counters, first-error capture and output registers
  always_ff @(posedge GCLK_Pad) begin
    if (RST_Pad || start_acc) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      exp_pipe_q <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
        exp_pipe_q[i] <= exp_pipe_q[i-1];
      end
      vld_pipe_q[0] <= accept;
      idx_pipe_q[0] <= accept ? vec_q : '0;
      exp_pipe_q[0] <= accept ? exp_new : 3'b000;
    end

    if (RST_Pad) begin
      vec_q  <= '0;
      err_q  <= '0;
      fidx_q <= '0;
      fexp_q <= '0;
      fgot_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      if (start_acc) begin
        fidx_q <= '0;
        fexp_q <= '0;
        fgot_q <= '0;
      end else if (err_hit && err_q == '0) begin
        fidx_q <= vld_pipe_q[LATENCY-1] ? idx_pipe_q[LATENCY-1] : '1;
        fexp_q <= vld_pipe_q[LATENCY-1] ? exp_pipe_q[LATENCY-1] : 3'b000;
        fgot_q <= got;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_ksa2_result_checker.sv
// Bench for ksa2_result_checker: two instances (CNT_W=8 and CNT_W=2) share stimulus.
// Adder responses are scheduled by absolute clock edge; the expected results
// come from operand arithmetic and the list of injected faults.
module tb_ksa2_result_checker;
  localparam int L  = 3;
  localparam int WU = 20;

  logic GCLK_Pad = 1'b0;
  always #5 GCLK_Pad = ~GCLK_Pad;

  logic RST_Pad, start, vec_valid, vec_last;
  logic a0, a1, b0, b1, cin, sum0, sum1, cout;
  logic       busy, done, pass;
  logic [7:0] vc, ec, fi;
  logic [2:0] fe, fg;
  logic       busy2, done2, pass2;
  logic [1:0] vc2, ec2, fi2;
  logic [2:0] fe2, fg2;

  ksa2_result_checker #(.LATENCY(L), .WARMUP_CYC(WU), .CNT_W(8)) dut (
    .GCLK_Pad(GCLK_Pad), .RST_Pad(RST_Pad), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .a0_Pad(a0), .a1_Pad(a1), .b0_Pad(b0), .b1_Pad(b1), .cin_Pad(cin),
    .sum0_Pad(sum0), .sum1_Pad(sum1), .cout_Pad(cout),
    .busy(busy), .done(done), .pass(pass), .vec_count(vc), .err_count(ec),
    .first_err_idx(fi), .first_err_exp(fe), .first_err_got(fg));

  ksa2_result_checker #(.LATENCY(L), .WARMUP_CYC(WU), .CNT_W(2)) dut2 (
    .GCLK_Pad(GCLK_Pad), .RST_Pad(RST_Pad), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .a0_Pad(a0), .a1_Pad(a1), .b0_Pad(b0), .b1_Pad(b1), .cin_Pad(cin),
    .sum0_Pad(sum0), .sum1_Pad(sum1), .cout_Pad(cout),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vc2), .err_count(ec2),
    .first_err_idx(fi2), .first_err_exp(fe2), .first_err_got(fg2));

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       c;
    logic [2:0] exp;
  } vec_t;

  vec_t       tbl[10];
  logic [2:0] sched[int];
  int         nchk = 0, nfail = 0, ecnt = 0;
  bit         raw = 1'b0;
  int         m_err, m_fi;
  logic [2:0] m_fe, m_fg;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock: drive the scheduled adder response for the coming edge, then sample #1 after it.
  task automatic tick();
    if (!raw) begin
      {cout, sum1, sum0} = sched.exists(ecnt + 1) ? sched[ecnt + 1] : 3'b000;
      if (sched.exists(ecnt + 1)) sched.delete(ecnt + 1);
    end
    @(posedge GCLK_Pad);
    ecnt++;
    #1;
  endtask

  function automatic void rec_err(input int idx, input logic [2:0] e, input logic [2:0] g);
    if (m_err == 0) begin
      m_fi = idx;
      m_fe = e;
      m_fg = g;
    end
    m_err++;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);  chk({tag, ".done"}, done, 0);  chk({tag, ".pass"}, pass, 0);
    chk({tag, ".vc"}, vc, 0);      chk({tag, ".ec"}, ec, 0);      chk({tag, ".fi"}, fi, 0);
    chk({tag, ".fe"}, fe, 0);      chk({tag, ".fg"}, fg, 0);
    chk({tag, ".busy2"}, busy2, 0); chk({tag, ".vc2"}, vc2, 0);   chk({tag, ".ec2"}, ec2, 0);
  endtask

  task automatic check_all(input string tag, input int n);
    int e1, e2, v1, v2, x1, x2;
    e1 = (m_err > 255) ? 255 : m_err;
    e2 = (m_err > 3) ? 3 : m_err;
    v1 = (n > 255) ? 255 : n;
    v2 = (n > 3) ? 3 : n;
    x1 = (m_err == 0) ? 0 : (m_fi < 0) ? 255 : (m_fi > 255) ? 255 : m_fi;
    x2 = (m_err == 0) ? 0 : (m_fi < 0) ? 3 : (m_fi > 3) ? 3 : m_fi;
    chk({tag, ".done"}, done, 1);  chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pass"}, pass, (e1 == 0 && n != 0) ? 1 : 0);
    chk({tag, ".vc"}, vc, v1);     chk({tag, ".ec"}, ec, e1);     chk({tag, ".fi"}, fi, x1);
    chk({tag, ".fe"}, fe, m_fe);   chk({tag, ".fg"}, fg, m_fg);
    chk({tag, ".done2"}, done2, 1);
    chk({tag, ".pass2"}, pass2, (e2 == 0 && n != 0) ? 1 : 0);
    chk({tag, ".vc2"}, vc2, v2);   chk({tag, ".ec2"}, ec2, e2);   chk({tag, ".fi2"}, fi2, x2);
    chk({tag, ".fe2"}, fe2, m_fe); chk({tag, ".fg2"}, fg2, m_fg);
  endtask

  // mode 0: table vectors; 1: random with random faults; 2: random, all correct.
  // bad: -1 none, -2 every vector wrong, else the index answered with 000.
  task automatic session(input string tag, input int n, input int mode, input int bad,
                         input bit spur, input bit do_rst);
    logic [1:0] a, b;
    logic       c;
    logic [2:0] e, g;
    m_err = 0; m_fi = 0; m_fe = 3'b000; m_fg = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".start_busy"}, busy, 1);
    chk({tag, ".start_done"}, done, 0);
    chk({tag, ".start_ec"}, ec, 0);
    chk({tag, ".start_vc"}, vc, 0);
    // Warm-up: garbage on every input, including a start that must be ignored.
    raw = 1'b1;
    for (int w = 0; w < WU; w++) begin
      {cout, sum1, sum0} = 3'($urandom);
      {a1, a0, b1, b0, cin} = 5'($urandom);
      vec_valid = 1'($urandom);
      vec_last  = 1'($urandom);
      start     = (w == 10);
      tick();
    end
    raw = 1'b0;
    start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    chk({tag, ".wu_busy"}, busy, 1);
    chk({tag, ".wu_ec"}, ec, 0);
    chk({tag, ".wu_vc"}, vc, 0);
    if (spur) begin
      sched[ecnt + 1] = 3'b001;
      rec_err(-1, 3'b000, 3'b001);
      tick();
    end
    for (int i = 0; i < n; i++) begin
      if (mode != 0) repeat ($urandom % 3) tick();
      if (mode == 0) begin
        a = tbl[i].a; b = tbl[i].b; c = tbl[i].c;
      end else begin
        a = 2'($urandom); b = 2'($urandom); c = 1'($urandom);
      end
      e = 3'(int'(a) + int'(b) + int'(c));
      g = (mode == 0) ? tbl[i].exp : e;
      if (bad == i) g = 3'b000;
      if (bad == -2 || (mode == 1 && $urandom % 4 == 0)) g = e ^ 3'(1 + $urandom % 7);
      if (g != e) rec_err(i, e, g);
      {a1, a0} = a; {b1, b0} = b; cin = c;
      vec_valid = 1'b1;
      vec_last  = (i == n - 1) && !do_rst;
      sched[ecnt + 1 + L] = g;
      tick();
      vec_valid = 1'b0; vec_last = 1'b0;
    end
    if (do_rst) begin
      RST_Pad = 1'b1;
      tick();
      RST_Pad = 1'b0;
      chk_zero({tag, ".rst"});
      repeat (L + 2) tick();
      chk_zero({tag, ".post_rst"});
    end else begin
      repeat (L - 1) tick();
      chk({tag, ".drain_busy"}, busy, 1);
      chk({tag, ".drain_done"}, done, 0);
      tick();
      check_all(tag, n);
    end
  endtask

  initial begin
    tbl[0] = '{2'd2, 2'd1, 1'b1, 3'b100};
    tbl[1] = '{2'd1, 2'd1, 1'b0, 3'b010};
    tbl[2] = '{2'd2, 2'd0, 1'b0, 3'b010};
    tbl[3] = '{2'd1, 2'd1, 1'b0, 3'b010};
    tbl[4] = '{2'd2, 2'd3, 1'b0, 3'b101};
    tbl[5] = '{2'd2, 2'd3, 1'b1, 3'b110};
    tbl[6] = '{2'd0, 2'd3, 1'b0, 3'b011};
    tbl[7] = '{2'd2, 2'd0, 1'b1, 3'b011};
    tbl[8] = '{2'd2, 2'd3, 1'b0, 3'b101};
    tbl[9] = '{2'd0, 2'd2, 1'b0, 3'b010};

    RST_Pad = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    {a0, a1, b0, b1, cin, sum0, sum1, cout} = 8'h00;
    repeat (3) tick();
    chk_zero("reset");
    RST_Pad = 1'b0;
    tick();

    session("clean10", 10, 0, -1, 1'b0, 1'b0);
    chk("clean10.spec_pass", pass, 1);
    chk("clean10.spec_vc", vc, 10);
    session("bad_idx1", 10, 0, 1, 1'b0, 1'b0);
    chk("bad_idx1.spec_fi", fi, 1);
    chk("bad_idx1.spec_fe", fe, 3'b010);
    chk("bad_idx1.spec_fg", fg, 3'b000);
    session("spurious", 1, 2, -1, 1'b1, 1'b0);
    chk("spurious.spec_fi", fi, 8'hFF);
    chk("spurious.spec_fg", fg, 3'b001);
    session("abort", 5, 2, -1, 1'b0, 1'b1);
    session("sat5", 5, 2, -2, 1'b0, 1'b0);
    chk("sat5.spec_ec2", ec2, 3);
    chk("sat5.spec_vc2", vc2, 3);
    chk("sat5.spec_fi2", fi2, 0);
    for (int k = 0; k < 6; k++)
      session($sformatf("rand%0d", k), 1 + int'($urandom % 12), 1, -1, (k == 3), 1'b0);
    session("long300", 300, 1, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
